// File: rtl/int_ctrl.sv
// Eight-line interrupt controller: rising-edge capture into pending, enable mask,
// in-service tracking, and one-hot priority vectors for the CPU control unit.
module int_ctrl #(
    parameter int unsigned       N_IRQ    = 8,
    parameter logic [N_IRQ-1:0]  MASK_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             we_mask,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic [N_IRQ-1:0] s_calli,
    input  logic [N_IRQ-1:0] s_reti,
    output logic [N_IRQ-1:0] min_bit_s,
    output logic [N_IRQ-1:0] min_bit_a,
    output logic [N_IRQ-1:0] pending_out,
    output logic [N_IRQ-1:0] mask_out
);

    localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_irq_q2;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_in_service;
    logic [N_IRQ-1:0] r_mask;

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_serviceable;

    assign w_rise = r_irq_q & ~r_irq_q2;

    // s_calli / s_reti are single-cycle strobes with no back-pressure: each bit
    // set in a cycle is consumed on the following edge. Multi-bit strobes apply bitwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q      <= '0;
            r_irq_q2     <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= MASK_RST;
        end else begin
            r_irq_q      <= irq;
            r_irq_q2     <= r_irq_q;
            // A fresh edge wins over a same-cycle accept so no request is lost.
            r_pending    <= w_rise | (r_pending & ~s_calli);
            // Accept wins over return; s_calli[0] also covers overflow, which has no pending bit.
            r_in_service <= s_calli | (r_in_service & ~s_reti);
            if (we_mask) begin
                r_mask <= mask_in;
            end
        end
    end

    assign w_serviceable = r_pending & r_mask;

    // Two's-complement isolate of the lowest set bit; bit 0 is highest priority.
    assign min_bit_s   = w_serviceable & (~w_serviceable + ONE);
    assign min_bit_a   = r_in_service & (~r_in_service + ONE);
    assign pending_out = r_pending;
    assign mask_out    = r_mask;

endmodule
